strided_window_router: RTL

//  Parametrised successor of memory_top: on-chip byte buffer plus a gather engine that

---
 rtl/strided_window_router.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/strided_window_router.sv
// Byte buffer with a strided gather engine: packs up to MaxWidth elements per window into
// one wide word and streams a batch of windows out under valid/ready flow control.
module strided_window_router #(
  parameter int MaxWidth   = 9,
  parameter int Depth      = 32,
  parameter int DataWidth  = 8,
  parameter int MaxWindows = 16,
  parameter int AddrWidth  = $clog2(Depth),
  parameter int CntWidth   = $clog2(MaxWidth + 1),
  parameter int WinWidth   = $clog2(MaxWindows + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          writeEn,
  input  logic [AddrWidth-1:0]          writeAddr,
  input  logic [DataWidth-1:0]          dataIn,
  input  logic                          routeEn,
  input  logic [AddrWidth-1:0]          startAddr,
  input  logic [CntWidth-1:0]           count,
  input  logic [AddrWidth-1:0]          stride,
  input  logic [WinWidth-1:0]           numWindows,
  input  logic [AddrWidth-1:0]          windowStep,
  input  logic                          outReady,
  output logic                          outValid,
  output logic [MaxWidth*DataWidth-1:0] dataOut,
  output logic                          busy,
  output logic                          finished
);

  // DRAIN waits for the last in-flight read to land before presenting the window.
  typedef enum logic [2:0] {IDLE, READ, DRAIN, HOLD, DONE} state_t;

  state_t               state;
  state_t               next_state;
  logic [DataWidth-1:0] mem [Depth];
  logic [DataWidth-1:0] rd_data;
  logic [AddrWidth-1:0] cur_addr;
  logic [AddrWidth-1:0] win_base;
  logic [AddrWidth-1:0] next_base;
  logic [AddrWidth-1:0] stride_r;
  logic [AddrWidth-1:0] step_r;
  logic [CntWidth-1:0]  cnt_r;
  logic [CntWidth-1:0]  issue_idx;
  logic [CntWidth-1:0]  rd_lane;
  logic [CntWidth-1:0]  cnt_eff;
  logic [WinWidth-1:0]  win_rem;
  logic [WinWidth-1:0]  nw_eff;
  logic                 rd_valid;
  logic                 start;
  logic                 zero_cfg;
  logic                 issue;
  logic                 last_issue;
  logic                 handshake;
  logic                 last_win;

  // Control decode: clamping, start qualification and handshake detection.
  always_comb begin
    cnt_eff    = (count > CntWidth'(MaxWidth)) ? CntWidth'(MaxWidth) : count;
    nw_eff     = (numWindows > WinWidth'(MaxWindows)) ? WinWidth'(MaxWindows) : numWindows;
    start      = routeEn && ((state == IDLE) || (state == DONE));
    zero_cfg   = (cnt_eff == '0) || (nw_eff == '0);
    issue      = (state == READ);
    last_issue = issue && (issue_idx == (cnt_r - CntWidth'(1)));
    handshake  = (state == HOLD) && outReady;
    last_win   = (win_rem == WinWidth'(1));
    next_base  = win_base + step_r;
  end

  assign busy = (state == READ) || (state == DRAIN) || (state == HOLD);

  // Buffer: write port plus read-first synchronous read of the current gather address.
  always_ff @(posedge clk) begin
    if (writeEn) begin
      mem[writeAddr] <= dataIn;
    end
    rd_data <= mem[cur_addr];
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // FSM next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          next_state = zero_cfg ? DONE : READ;
        end else begin
          next_state = state;
        end
      end
      READ: begin
        if (last_issue) begin
          next_state = DRAIN;
        end else begin
          next_state = READ;
        end
      end
      DRAIN: next_state = HOLD;
      HOLD: begin
        if (handshake) begin
          next_state = last_win ? DONE : READ;
        end else begin
          next_state = HOLD;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Gather datapath: config latch, address walk, lane fill and output handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outValid  <= 1'b0;
      dataOut   <= '0;
      finished  <= 1'b0;
      cur_addr  <= '0;
      win_base  <= '0;
      stride_r  <= '0;
      step_r    <= '0;
      cnt_r     <= '0;
      issue_idx <= '0;
      rd_lane   <= '0;
      win_rem   <= '0;
      rd_valid  <= 1'b0;
    end else begin
      rd_valid <= issue;
      rd_lane  <= issue_idx;
      if (start) begin
        cur_addr  <= startAddr;
        win_base  <= startAddr;
        stride_r  <= stride;
        step_r    <= windowStep;
        cnt_r     <= cnt_eff;
        win_rem   <= nw_eff;
        issue_idx <= '0;
        dataOut   <= '0;
        outValid  <= 1'b0;
        finished  <= zero_cfg;
      end else if (issue) begin
        cur_addr  <= cur_addr + stride_r;
        issue_idx <= issue_idx + CntWidth'(1);
      end else begin
        cur_addr <= cur_addr;
      end
      if (rd_valid) begin
        for (int i = 0; i < MaxWidth; i++) begin
          if (rd_lane == CntWidth'(i)) begin
            dataOut[i*DataWidth +: DataWidth] <= rd_data;
          end
        end
      end
      if (state == DRAIN) begin
        outValid <= 1'b1;
      end
      // Window handoff: last window finishes the batch, otherwise the next window starts clean.
      if (handshake) begin
        outValid <= 1'b0;
        win_rem  <= win_rem - WinWidth'(1);
        if (last_win) begin
          finished <= 1'b1;
        end else begin
          win_base  <= next_base;
          cur_addr  <= next_base;
          issue_idx <= '0;
          dataOut   <= '0;
        end
      end
    end
  end

endmodule
